pc_fetch_unit: RTL
==================

# pc_fetch_unit

Program-counter register and instruction-fetch request controller for the single-cycle RISC-V core. It holds the architectural PC, drives it to the instruction memory over a valid/ready request channel, and loads the next PC from `pc_adder` (PC+4) or from a branch/jump redirect. It also buffers redirects that arrive while a request is outstanding and halts on a misaligned target.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC value after reset; must be 4-byte aligned.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous reset, active-high.
- `pc_next_in` input 32: sequential next PC from `pc_adder` (pc_out + 4).
- `redirect_valid` input 1: branch/jump taken this cycle.
- `redirect_target` input 32: redirect destination; sampled only when `redirect_valid`=1.
- `stall` input 1: forbids starting a new fetch request.
- `imem_req_ready` input 1: instruction memory accepts the request.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_addr` output 32: fetch address; always equals `pc_out`.
- `pc_out` output 32: current PC, also feeds `pc_adder`.
- `misalign_fault` output 1: sticky; a misaligned redirect was seen.
- `fault_pc` output 32: offending redirect target.
- `fetch_count` output 32: number of completed handshakes, wraps modulo 2^32.

## Operation
- FSM states: S_BOOT, S_FETCH, S_FAULT.
  - S_BOOT → S_FETCH unconditionally after one cycle.
  - S_FETCH → S_FAULT on an accepted misaligned redirect.
  - S_FAULT is held until `rst`.
- Handshake: a fetch completes when `imem_req_valid` && `imem_req_ready` are both high on a clock edge.
- `req_hold` flag:
  - Set when valid && !ready.
  - Cleared on handshake.
- `imem_req_valid` = (state==S_FETCH) && (!stall || req_hold).
  - Once raised, valid stays high until handshake, regardless of `stall`.
  - `imem_req_addr` is stable while valid && !ready.
- PC update happens only on a handshake, with this priority:
  - Live `redirect_valid` this cycle: `redirect_target`.
  - Else, a buffered redirect: the buffered target; the buffer then clears.
  - Else: `pc_next_in`.
- Redirect without handshake in the same cycle (valid low, or valid && !ready):
  - The target is latched into a one-entry buffer (`redir_pend`, `redir_tgt`).
  - A newer redirect overwrites the buffer.
- Alignment is checked when a redirect is captured (live or into the buffer): `redirect_target[1:0] != 0` is a fault.
  - `misalign_fault` goes to 1 and `fault_pc` takes the target.
  - State goes to S_FAULT.
  - The PC is not updated and the buffer is cleared.
  - `imem_req_valid` drops next cycle, even with a request outstanding; the memory must tolerate an abandoned request.
- `fetch_count` increments by 1 on every handshake. It wraps from 32'hFFFF_FFFF to 0.
- The block issues no requests in S_BOOT or S_FAULT.

## Timing
- Reset values:
  - `pc_out` = `RESET_VECTOR`.
  - `imem_req_valid`=0, `misalign_fault`=0, `fault_pc`=0, `fetch_count`=0.
  - State S_BOOT; `req_hold`=0; `redir_pend`=0.
- Boot timing, with `rst` deasserted before edge 0:
  - Edge 0 leaves the block in S_BOOT, with valid=0.
  - Edge 1 enters S_FETCH.
  - Valid is high in the cycle after edge 1, with addr=`RESET_VECTOR`.
- Handshake at edge N: the new `pc_out` is visible after edge N. With ready held high and no stall, the block sustains one fetch per cycle.
- All outputs are registered or derived from registers and inputs through a single gate level. There is no combinational path from `redirect_*` to `imem_req_addr`.
- `rst` asserted mid-request: reset values take effect at the next edge, and any buffered redirect or fault is discarded.
- Stall and handshake in the same cycle (`req_hold`=1): the handshake completes and the PC advances. A new request is not raised while `stall`=1.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN`=32.
  - `INSTR_ALIGN_MASK`=32'h3.
  - The `pc_state_t` enum {S_BOOT, S_FETCH, S_FAULT}.
  - The default reset vector constant.
- One sub-module, `pc_redirect_buf`, is natural: the one-entry redirect buffer, with capture/overwrite/clear logic and a pending flag.
- `pc_adder` stays external; `pc_out` drives it and its result returns on `pc_next_in`.

## Test plan
- Reset and boot, `RESET_VECTOR`=32'h0000_1000, ready=1: addr sequence is 0x1000, 0x1004, 0x1008 on consecutive cycles, and `fetch_count`=3 after three handshakes.
- Backpressure: ready=0 for 3 cycles at addr 0x1004 with `stall` pulsed high → valid stays 1 and addr stays 0x1004. On ready=1 the PC goes to 0x1008.
- Redirect during wait: redirect 0x2000 while valid && !ready, then redirect 0x3000 → after the handshake, the PC is 0x3000.
- Simultaneous redirect and handshake at PC 0x1008 with target 0x4000 → the next PC is 0x4000, not 0x100C.
- Misaligned redirect 0x2002 → `misalign_fault`=1, `fault_pc`=0x2002, valid=0 and `pc_out` unchanged. After `rst`, the block returns to the `RESET_VECTOR` boot sequence.
- Counter wrap: preload or run `fetch_count` to 32'hFFFF_FFFF → the next handshake yields 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, alignment mask, fetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INSTR_ALIGN_MASK     = 32'h0000_0003;
    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_FAULT
    } pc_state_t;

    // Instructions are 4-byte aligned; any low address bit set is a fault.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr & INSTR_ALIGN_MASK) != '0;
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-fetch request channel between the PC unit and instruction memory.
// Latency: n/a (wires only).
// Backpressure: memory holds off a request by keeping imem_req_ready low.
// Signals: imem_req_valid / imem_req_addr from the requester, imem_req_ready back.
interface pc_fetch_if;
    import riscv_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready
    );

endinterface

// File: rtl/pc_redirect_buf.sv
// One-entry buffer for a branch/jump target that arrived while no fetch could complete.
// Latency: captured target visible one cycle after capture.
// Backpressure: none; a newer capture overwrites the held target.
// Ports: capture/clear strobes, tgt_in in; pend flag and held tgt out.
module pc_redirect_buf
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            capture,
    input  logic            clear,
    input  logic [XLEN-1:0] tgt_in,
    output logic            pend,
    output logic [XLEN-1:0] tgt
);

    // Clear wins over capture: a fault or a consuming handshake empties the entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            tgt  <= '0;
        end else if (clear) begin
            pend <= 1'b0;
        end else if (capture) begin
            pend <= 1'b1;
            tgt  <= tgt_in;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch request controller with redirect buffering and misalign halt.
// Latency: new PC visible the edge after a handshake; one fetch per cycle with ready held high.
// Backpressure: an issued request holds valid and addr until accepted, ignoring stall.
// Ports: clk/rst, pc_next_in from pc_adder, redirect_*, stall, imem (master), pc_out, fault and count outputs.
module pc_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR     = DEFAULT_RESET_VECTOR,
    // Counter value after reset; nonzero only to exercise wrap-around quickly.
    parameter logic [XLEN-1:0] FETCH_COUNT_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_next_in,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             stall,
    pc_fetch_if.master       imem,
    output logic [XLEN-1:0]  pc_out,
    output logic             misalign_fault,
    output logic [XLEN-1:0]  fault_pc,
    output logic [XLEN-1:0]  fetch_count
);

    pc_state_t       state_q;
    logic            boot_q;
    logic [XLEN-1:0] pc_q;
    logic            req_hold_q;

    logic            in_fetch;
    logic            req_valid;
    logic            handshake;
    logic            redir_live;
    logic            redir_bad;
    logic            redir_ok;
    logic            buf_pend;
    logic [XLEN-1:0] buf_tgt;

    assign in_fetch   = (state_q == S_FETCH);
    assign req_valid  = in_fetch && (!stall || req_hold_q);
    assign handshake  = req_valid && imem.imem_req_ready;

    // Redirects are only acted on while fetching; boot and fault ignore them.
    assign redir_live = redirect_valid && in_fetch;
    assign redir_bad  = redir_live && is_misaligned(redirect_target);
    assign redir_ok   = redir_live && !redir_bad;

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = pc_q;
    assign pc_out              = pc_q;

    pc_redirect_buf u_redirect_buf (
        .clk     (clk),
        .rst     (rst),
        .capture (redir_ok && !handshake),
        .clear   (redir_bad || handshake),
        .tgt_in  (redirect_target),
        .pend    (buf_pend),
        .tgt     (buf_tgt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_BOOT;
            boot_q         <= 1'b0;
            pc_q           <= RESET_VECTOR;
            req_hold_q     <= 1'b0;
            misalign_fault <= 1'b0;
            fault_pc       <= '0;
            fetch_count    <= FETCH_COUNT_INIT;
        end else begin
            if (handshake) begin
                fetch_count <= fetch_count + 1'b1;
            end

            case (state_q)
                // Two edges in boot after reset release: the first arms boot_q.
                S_BOOT: begin
                    if (boot_q) begin
                        state_q <= S_FETCH;
                    end else begin
                        boot_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (redir_bad) begin
                        // Abandon any outstanding request; PC stays put.
                        state_q        <= S_FAULT;
                        misalign_fault <= 1'b1;
                        fault_pc       <= redirect_target;
                        req_hold_q     <= 1'b0;
                    end else if (handshake) begin
                        req_hold_q <= 1'b0;
                        if (redirect_valid) begin
                            pc_q <= redirect_target;
                        end else if (buf_pend) begin
                            pc_q <= buf_tgt;
                        end else begin
                            pc_q <= pc_next_in;
                        end
                    end else if (req_valid) begin
                        req_hold_q <= 1'b1;
                    end
                end
                S_FAULT: begin
                    req_hold_q <= 1'b0;
                end
                default: begin
                    state_q <= S_BOOT;
                end
            endcase
        end
    end

endmodule
